// File: rtl/ddr3_gray_frame_reader.sv
// ddr3_gray_frame_reader
// Streams the most recently completed 16K-word DDR3 frame buffer out through
// an Avalon-MM pipelined read master and a show-ahead FIFO. Read commands are
// credit limited so returned data always has a FIFO slot waiting for it.
//
// Handshakes: a read command transfers on a cycle with ddr3_read && !ddr3_waitrequest;
// command and address stay stable while stalled. Each ddr3_readdatavalid cycle
// returns one word. An output word transfers on a cycle with out_valid && out_ready.
module ddr3_gray_frame_reader #(
  parameter int WORDS_PER_LINE  = 24,
  parameter int LINES           = 480,
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic         ddr3_clk,
  input  logic         ddr3clk_reset,
  input  logic [31:0]  start_address_i,
  input  logic [1:0]   pointer_data,
  input  logic         pointer_valid,
  input  logic         frame_start,
  output logic [26:0]  ddr3_read_address,
  output logic         ddr3_read,
  input  logic         ddr3_waitrequest,
  input  logic [255:0] ddr3_readdata,
  input  logic         ddr3_readdatavalid,
  output logic [255:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sof,
  output logic         out_eol,
  output logic         busy,
  output logic         overrun
);

  localparam int WW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    buffer_q, buffer_d;
  logic [26:0]   addr_q, addr_d;
  logic [WW-1:0] word_q, word_d;
  logic [LW-1:0] line_q, line_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [WW-1:0] rword_q, rword_d;
  logic [LW-1:0] rline_q, rline_d;
  logic          overrun_q, overrun_d;

  logic [255:0]  fifo_mem [FIFO_DEPTH];

  logic [CW-1:0] fifo_used;
  logic          fifo_empty;
  logic [SW-1:0] credit_sum;
  logic          rd_cmd;
  logic          accept;
  logic          ret_ok;
  logic          pop;
  logic          last_word;
  logic          last_line;
  logic [26:0]   start_base;
  logic          unused_addr_bits;

  // Byte-offset bits of the base address carry no word information.
  assign unused_addr_bits = ^start_address_i[4:0];

  // Credit, handshake and snapshot terms shared by the next-state logic.
  always_comb begin
    fifo_used  = wr_ptr_q - rd_ptr_q;
    fifo_empty = (fifo_used == '0);
    credit_sum = SW'(outstanding_q) + SW'(fifo_used);
    rd_cmd     = (state_q == S_ISSUE) &&
                 (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                 (credit_sum < SW'(FIFO_DEPTH));
    accept     = rd_cmd && !ddr3_waitrequest;
    ret_ok     = ddr3_readdatavalid && (outstanding_q != '0);
    pop        = !fifo_empty && out_ready;
    last_word  = (word_q == WW'(WORDS_PER_LINE - 1));
    last_line  = (line_q == LW'(LINES - 1));
    buffer_d   = pointer_valid ? pointer_data : buffer_q;
    start_base = start_address_i[31:5] + 27'({buffer_d, 14'b0});
  end

  // Frame FSM, issue-side address/word/line counters and sticky overrun.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    line_d    = line_q;
    overrun_d = overrun_q | (frame_start && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_ISSUE;
          addr_d  = start_base;
          word_d  = '0;
          line_d  = '0;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          addr_d = addr_q + 27'd1;
          if (last_word) begin
            word_d = '0;
            if (last_line) begin
              line_d  = '0;
              state_d = S_DRAIN;
            end else begin
              line_d = line_q + LW'(1);
            end
          end else begin
            word_d = word_q + WW'(1);
          end
        end
      end
      S_DRAIN: begin
        if ((outstanding_q == '0) && fifo_empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outstanding-command count, FIFO pointers and return-side word/line position.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !ret_ok)      outstanding_d = outstanding_q + OW'(1);
    else if (!accept && ret_ok) outstanding_d = outstanding_q - OW'(1);
    wr_ptr_d = wr_ptr_q + CW'(ret_ok);
    rd_ptr_d = rd_ptr_q + CW'(pop);
    rword_d  = rword_q;
    rline_d  = rline_q;
    if (pop) begin
      if (rword_q == WW'(WORDS_PER_LINE - 1)) begin
        rword_d = '0;
        rline_d = (rline_q == LW'(LINES - 1)) ? '0 : rline_q + LW'(1);
      end else begin
        rword_d = rword_q + WW'(1);
      end
    end
    if ((state_q == S_IDLE) && frame_start) begin
      rword_d = '0;
      rline_d = '0;
    end
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge ddr3_clk or posedge ddr3clk_reset) begin
    if (ddr3clk_reset) begin
      state_q       <= S_IDLE;
      buffer_q      <= '0;
      addr_q        <= '0;
      word_q        <= '0;
      line_q        <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rword_q       <= '0;
      rline_q       <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      buffer_q      <= buffer_d;
      addr_q        <= addr_d;
      word_q        <= word_d;
      line_q        <= line_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rword_q       <= rword_d;
      rline_q       <= rline_d;
      overrun_q     <= overrun_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge ddr3_clk) begin
    if (ret_ok) fifo_mem[wr_ptr_q[AW-1:0]] <= ddr3_readdata;
  end

  // Output drive; data and markers are forced low whenever the FIFO is empty.
  always_comb begin
    ddr3_read         = rd_cmd;
    ddr3_read_address = addr_q;
    out_valid         = !fifo_empty;
    out_data          = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    out_sof           = !fifo_empty && (rword_q == '0) && (rline_q == '0);
    out_eol           = !fifo_empty && (rword_q == WW'(WORDS_PER_LINE - 1));
    busy              = (state_q != S_IDLE);
    overrun           = overrun_q;
  end

endmodule

// File: tb/tb_ddr3_gray_frame_reader.sv
// Testbench for ddr3_gray_frame_reader: address-tagged DDR3 read slave,
// expected-word queue filled at frame_start, monitor popping on each output.
module tb_ddr3_gray_frame_reader;

  localparam int WPL   = 24;
  localparam int LINES = 480;
  localparam int FRAME = WPL * LINES;
  localparam int LAT   = 6;

  logic         clk;
  logic         rst;
  logic [31:0]  start_address_i;
  logic [1:0]   pointer_data;
  logic         pointer_valid;
  logic         frame_start;
  logic [26:0]  ddr3_read_address;
  logic         ddr3_read;
  logic         ddr3_waitrequest;
  logic [255:0] ddr3_readdata;
  logic         ddr3_readdatavalid;
  logic [255:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sof;
  logic         out_eol;
  logic         busy;
  logic         overrun;

  ddr3_gray_frame_reader dut (
    .ddr3_clk           (clk),
    .ddr3clk_reset      (rst),
    .start_address_i    (start_address_i),
    .pointer_data       (pointer_data),
    .pointer_valid      (pointer_valid),
    .frame_start        (frame_start),
    .ddr3_read_address  (ddr3_read_address),
    .ddr3_read          (ddr3_read),
    .ddr3_waitrequest   (ddr3_waitrequest),
    .ddr3_readdata      (ddr3_readdata),
    .ddr3_readdatavalid (ddr3_readdatavalid),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_sof            (out_sof),
    .out_eol            (out_eol),
    .busy               (busy),
    .overrun            (overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [257:0] exp_q[$];          // {sof, eol, data}
  logic [26:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          acc_count = 0;
  logic [26:0] exp_addr_next = '0;
  logic [26:0] frame_base = '0;
  logic        frame_active = 1'b0;
  logic        stall_en = 1'b0;
  int          stall_left = 0;
  int          ready_mode = 2;     // 0 low, 1 random, 2 high
  logic        stale_window = 1'b0;
  int          stale_seen = 0;

  function automatic logic [255:0] mk_data(input logic [26:0] a);
    logic [31:0] w;
    w = {5'd0, a};
    return {w ^ 32'hDEAD_0000, w, ~w, w ^ 32'h1234_5678,
            w + 32'd1, w, w ^ 32'hFFFF_0000, w};
  endfunction

  task automatic chk(input string name, input logic [257:0] act, input logic [257:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DDR3 read slave (address-tagged memory model) ----------------
  initial begin
    ddr3_waitrequest   = 1'b0;
    ddr3_readdatavalid = 1'b0;
    ddr3_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        ddr3_readdatavalid = 1'b1;
        ddr3_readdata      = mk_data(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        ddr3_readdatavalid = 1'b0;
        ddr3_readdata      = '0;
      end
      ddr3_waitrequest = stall_en && (acc_count == 3) && (stall_left > 0);
      if (ddr3_waitrequest) stall_left--;
      @(negedge clk);
      if (stale_window && ddr3_readdatavalid) stale_seen++;
      if (ddr3_waitrequest && stall_en) begin
        chk("stall_read_held", ddr3_read, 1'b1);
        chk("stall_addr_held", ddr3_read_address, frame_base + 27'd3);
      end
      if (ddr3_read && !ddr3_waitrequest) begin
        if (frame_active) begin
          chk(acc_count == 0 ? "first_addr" : "addr", ddr3_read_address, exp_addr_next);
          exp_addr_next = exp_addr_next + 27'd1;
        end
        acc_count++;
        pend_addr.push_back(ddr3_read_address);
        pend_due.push_back(cyc + LAT);
      end
    end
  end

  // ---------------- output ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [257:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h with no word expected", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", {out_sof, out_eol, out_data}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [26:0] base, input logic pv, input logic [1:0] pd);
    tick();
    frame_base    = base;
    exp_addr_next = base;
    acc_count     = 0;
    frame_active  = 1'b1;
    for (int i = 0; i < FRAME; i++)
      exp_q.push_back({(i == 0), ((i % WPL) == WPL - 1), mk_data(base + 27'(i))});
    frame_start   = 1'b1;
    pointer_valid = pv;
    pointer_data  = pd;
    @(negedge clk);
    chk("busy_before_start", busy, 1'b0);
    tick();
    frame_start   = 1'b0;
    pointer_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("frame_done_in_time", (i < budget), 1'b1);
    chk("all_words_out", exp_q.size(), 0);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (acc_count >= n) break;
    end
    chk("cmds_reached_in_time", (i < budget), 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int reads_seen;
    rst             = 1'b1;
    start_address_i = 32'h0000_0000;
    pointer_data    = 2'd0;
    pointer_valid   = 1'b0;
    frame_start     = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_read", ddr3_read, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_sof_eol", {out_sof, out_eol}, 2'b00);
    chk("rst_out_data", out_data, 256'd0);
    tick();
    rst = 1'b0;

    // Frame A: buffer 2, ready held low first, stall on command 3.
    tick();
    pointer_valid = 1'b1;
    pointer_data  = 2'd2;
    tick();
    pointer_valid = 1'b0;
    ready_mode    = 0;
    stall_en      = 1'b1;
    stall_left    = 5;
    start_frame(27'h8000, 1'b0, 2'd0);
    repeat (300) @(negedge clk);
    chk("credit_stop_count", acc_count, 64);
    chk("credit_stop_read", ddr3_read, 1'b0);
    chk("full_head_valid", out_valid, 1'b1);
    chk("full_head_sof", out_sof, 1'b1);
    chk("full_head_data", out_data, mk_data(27'h8000));
    stall_en   = 1'b0;
    ready_mode = 1;
    wait_acc(2000, 10000);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("overrun_set", overrun, 1'b1);
    chk("busy_during_overrun", busy, 1'b1);
    tick();
    pointer_valid = 1'b1;
    pointer_data  = 2'd1;
    tick();
    pointer_valid = 1'b0;
    wait_idle(40000);
    chk("frame_a_cmds", acc_count, FRAME);
    frame_active = 1'b0;
    reads_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ddr3_read || out_valid || busy) reads_seen++;
    end
    chk("no_second_frame", reads_seen, 0);
    chk("overrun_sticky", overrun, 1'b1);

    // Frame B: buffer updated mid-frame A to 1.
    start_frame(27'h4000, 1'b0, 2'd0);
    wait_idle(40000);
    chk("frame_b_cmds", acc_count, FRAME);
    frame_active = 1'b0;

    // Frame C: reset after 100 commands, stale returns keep arriving.
    start_frame(27'h4000, 1'b0, 2'd0);
    wait_acc(100, 5000);
    tick();
    rst          = 1'b1;
    frame_active = 1'b0;
    stale_window = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_read_drops", ddr3_read, 1'b0);
    chk("rst_valid_drops", out_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) rst = 1'b0;
      @(negedge clk);
      chk("stale_out_valid", out_valid, 1'b0);
      chk("stale_read", ddr3_read, 1'b0);
    end
    stale_window = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    chk("stale_returns_seen", (stale_seen > 0), 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_overrun", overrun, 1'b0);

    // Frame D: pointer update coincident with frame_start, base wraps.
    start_address_i = 32'hFFFF_FFE0;
    ready_mode      = 2;
    start_frame(27'h000BFFF, 1'b1, 2'd3);
    wait_idle(40000);
    chk("frame_d_cmds", acc_count, FRAME);
    frame_active = 1'b0;

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
